// File: rtl/cpu_mem_responder_if.sv
// CPU-side instruction/data port bundle for cpu_mem_responder.
// The master modport is the CPU; the slave modport is the memory responder.
interface cpu_mem_responder_if #(
   parameter int unsigned ADDR_W = 10
);
   logic [ADDR_W-1:0] instruction_address;
   logic              read_inst_enable;
   logic [31:0]       instruction;
   logic [ADDR_W-1:0] data_address;
   logic              data_read;
   logic              write_mem;
   logic [3:0]        width;
   logic [31:0]       data_out;
   logic [31:0]       data_in;
   logic              mem_stall;

   modport master (
      output instruction_address, read_inst_enable,
      output data_address, data_read, write_mem, width, data_out,
      input  instruction, data_in, mem_stall
   );

   modport slave (
      input  instruction_address, read_inst_enable,
      input  data_address, data_read, write_mem, width, data_out,
      output instruction, data_in, mem_stall
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Single-port shared instruction/data memory; data wins conflicts and the fetch is replayed.
// Define STALL_COUNT_EN to add a saturating stall_count output.
module cpu_mem_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               reset,
   cpu_mem_responder_if.slave bus
`ifdef STALL_COUNT_EN
   ,
   output logic [31:0]        stall_count
`endif
);
   localparam int unsigned WORD_AW = ADDR_W - 2;
   localparam int unsigned DEPTH   = 1 << WORD_AW;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] REPLAY = 1'b1;

   logic [31:0]        mem [DEPTH];
   logic [0:0]         state;
   logic [0:0]         state_nxt;
   logic [WORD_AW-1:0] pend_addr;
   logic [WORD_AW-1:0] acc_addr;
   logic               dreq;
   logic               mem_we;
   logic               load_inst;
   logic               load_nop;
   logic               load_data;
   logic               latch_pend;
   logic               unused_addr_bits;

   // Byte-offset bits carry no meaning for word accesses.
   assign unused_addr_bits = ^{bus.instruction_address[1:0], bus.data_address[1:0]};
   assign dreq             = bus.data_read | bus.write_mem;

   always_comb begin
      state_nxt     = state;
      bus.mem_stall = 1'b0;
      acc_addr      = bus.instruction_address[ADDR_W-1:2];
      mem_we        = 1'b0;
      load_inst     = 1'b0;
      load_nop      = 1'b0;
      load_data     = 1'b0;
      latch_pend    = 1'b0;
      case (state)
         IDLE: begin
            if (dreq) begin
               acc_addr  = bus.data_address[ADDR_W-1:2];
               mem_we    = bus.write_mem;
               load_data = bus.data_read & ~bus.write_mem;
               if (bus.read_inst_enable) begin
                  // Data owns the port; hold instruction and replay the fetch next cycle.
                  bus.mem_stall = 1'b1;
                  latch_pend    = 1'b1;
                  state_nxt     = REPLAY;
               end else begin
                  load_nop = 1'b1;
               end
            end else if (bus.read_inst_enable) begin
               load_inst = 1'b1;
            end else begin
               load_nop = 1'b1;
            end
         end
         REPLAY: begin
            acc_addr      = pend_addr;
            bus.mem_stall = 1'b1;
            load_inst     = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.width[i]) mem[acc_addr][8*i +: 8] <= bus.data_out[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         pend_addr       <= '0;
         bus.instruction <= NOP_WORD;
         bus.data_in     <= '0;
      end else begin
         state <= state_nxt;
         if (latch_pend) pend_addr <= bus.instruction_address[ADDR_W-1:2];
         if (load_inst) begin
            bus.instruction <= mem[acc_addr];
         end else if (load_nop) begin
            bus.instruction <= NOP_WORD;
         end
         if (load_data) bus.data_in <= mem[acc_addr];
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (bus.mem_stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: a cycle predictor pushes expected outputs,
// and each scenario task pops and compares them once the DUT has produced them.
module tb_cpu_mem_responder;
   localparam int unsigned ADDR_W = 10;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct {
      logic        rst;
      logic        f;
      logic [9:0]  ia;
      logic        rd;
      logic        wr;
      logic [3:0]  w;
      logic [9:0]  da;
      logic [31:0] d;
   } stim_t;

   typedef struct {
      int          due;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cpu_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
   logic [31:0] cnt_obs;

`ifdef STALL_COUNT_EN
   logic [31:0] stall_count;
   cpu_mem_responder #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .bus(bus), .stall_count(stall_count));
   assign cnt_obs = stall_count;
`else
   cpu_mem_responder #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   assign cnt_obs = '0;
`endif

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic        last_stall;
   string       cur_test;

   // Reference model state
   logic [31:0] mm [256];
   logic        m_replay = 1'b0;
   bit          m_known  = 1'b0;
   logic [7:0]  m_pend;
   logic [31:0] m_inst;
   logic [31:0] m_din;
   logic [31:0] m_cnt;

   function automatic stim_t mk(input logic rst, input logic f, input logic [9:0] ia,
                                input logic rd, input logic wr, input logic [3:0] w,
                                input logic [9:0] da, input logic [31:0] d);
      stim_t s;
      s.rst = rst; s.f = f; s.ia = ia; s.rd = rd; s.wr = wr; s.w = w; s.da = da; s.d = d;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
   endfunction

   // Apply one cycle of stimulus, predict its outcome, and advance past the clock edge.
   task automatic drive(input stim_t s);
      logic exp_stall;
      exp_t e;
      reset                   = s.rst;
      bus.read_inst_enable    = s.f;
      bus.instruction_address = s.ia;
      bus.data_read           = s.rd;
      bus.write_mem           = s.wr;
      bus.width               = s.w;
      bus.data_address        = s.da;
      bus.data_out            = s.d;
      exp_stall = m_replay | ((s.rd | s.wr) & s.f);
      if (m_known) begin
         e.due = cyc + 1; e.kind = 2; e.val = {31'b0, exp_stall}; e.name = "mem_stall";
         sb.push_back(e);
      end
      if (s.rst) begin
         m_inst = NOP; m_din = '0; m_replay = 1'b0; m_pend = '0; m_cnt = '0; m_known = 1'b1;
      end else begin
         if (exp_stall && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
         if (m_replay) begin
            m_inst   = mm[m_pend];
            m_replay = 1'b0;
         end else if (s.rd | s.wr) begin
            if (s.wr) begin
               for (int i = 0; i < 4; i++)
                  if (s.w[i]) mm[s.da[9:2]][8*i +: 8] = s.d[8*i +: 8];
            end else begin
               m_din = mm[s.da[9:2]];
            end
            if (s.f) begin
               m_pend   = s.ia[9:2];
               m_replay = 1'b1;
            end else begin
               m_inst = NOP;
            end
         end else begin
            m_inst = s.f ? mm[s.ia[9:2]] : NOP;
         end
      end
      e.due = cyc + 1; e.kind = 0; e.val = m_inst; e.name = "instruction"; sb.push_back(e);
      e.due = cyc + 1; e.kind = 1; e.val = m_din;  e.name = "data_in";     sb.push_back(e);
`ifdef STALL_COUNT_EN
      e.due = cyc + 1; e.kind = 3; e.val = m_cnt;  e.name = "stall_count"; sb.push_back(e);
`endif
      #1 last_stall = bus.mem_stall;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      cur_test = "reset";
      q = '{mk(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0),
            mk(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0),
            idle(), idle()};
      foreach (q[i]) begin
         drive(q[i]);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
      end
      checks++;
      if (bus.instruction !== 32'h0000_0013) begin
         errors++; $display("FAIL reset nop: got %h expected 00000013", bus.instruction);
      end
      checks++;
      if (bus.data_in !== 32'h0 || last_stall !== 1'b0) begin
         errors++; $display("FAIL reset idle outputs: data_in %h stall %b expected 0/0", bus.data_in, last_stall);
      end
   endtask

   task automatic test_fetch();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      int stalls = 0;
      cur_test = "fetch";
      q = '{mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'hF, 10'h014, 32'hDEAD_BEEF),
            mk(1'b0, 1'b1, 10'h014, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0),
            idle()};
      foreach (q[i]) begin
         drive(q[i]);
         if (last_stall === 1'b1) stalls++;
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
         if (i == 1) begin
            checks++;
            if (bus.instruction !== 32'hDEAD_BEEF) begin
               errors++; $display("FAIL fetch word5: got %h expected deadbeef", bus.instruction);
            end
         end
      end
      checks++;
      if (stalls != 0) begin
         errors++; $display("FAIL fetch stall cycles: got %0d expected 0", stalls);
      end
   endtask

   task automatic test_byte_lanes();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      cur_test = "byte_lanes";
      q = '{mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'hF,    10'h020, 32'hAABB_CCDD),
            mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'b0101, 10'h020, 32'h1122_3344),
            mk(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 4'h0,    10'h020, 32'h0),
            mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'h0,    10'h020, 32'hFFFF_FFFF),
            mk(1'b0, 1'b0, 10'h0, 1'b1, 1'b1, 4'b1000, 10'h022, 32'h5500_0000),
            mk(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 4'h0,    10'h021, 32'h0)};
      foreach (q[i]) begin
         drive(q[i]);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
         if (i == 2 || i == 4) begin
            checks++;
            if (bus.data_in !== 32'hAA22_CC44) begin
               errors++; $display("FAIL lanes merge step %0d: got %h expected aa22cc44", i, bus.data_in);
            end
         end
         if (i == 5) begin
            checks++;
            if (bus.data_in !== 32'h5522_CC44) begin
               errors++; $display("FAIL lanes store+load: got %h expected 5522cc44", bus.data_in);
            end
         end
      end
   endtask

   task automatic test_conflict();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      int stalls = 0;
      cur_test = "conflict";
      q = '{mk(1'b0, 1'b0, 10'h0,   1'b0, 1'b1, 4'hF, 10'h004, 32'h1111_0001),
            mk(1'b0, 1'b0, 10'h0,   1'b0, 1'b1, 4'hF, 10'h008, 32'h2222_0002),
            mk(1'b0, 1'b1, 10'h004, 1'b1, 1'b0, 4'h0, 10'h008, 32'h0),
            mk(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 4'h0, 10'h0,   32'h0),
            idle(),
            mk(1'b0, 1'b1, 10'h008, 1'b0, 1'b1, 4'h0, 10'h004, 32'hFFFF_FFFF),
            mk(1'b0, 1'b1, 10'h008, 1'b0, 1'b0, 4'h0, 10'h0,   32'h0),
            idle()};
      foreach (q[i]) begin
         drive(q[i]);
         if (last_stall === 1'b1) stalls++;
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
         if (i == 2) begin
            checks++;
            if (bus.data_in !== 32'h2222_0002) begin
               errors++; $display("FAIL conflict load: got %h expected 22220002", bus.data_in);
            end
         end
         if (i == 3) begin
            checks++;
            if (bus.instruction !== 32'h1111_0001) begin
               errors++; $display("FAIL conflict replay: got %h expected 11110001", bus.instruction);
            end
         end
         if (i == 6) begin
            checks++;
            if (bus.instruction !== 32'h2222_0002) begin
               errors++; $display("FAIL zero-width replay: got %h expected 22220002", bus.instruction);
            end
         end
      end
      checks++;
      if (stalls != 4) begin
         errors++; $display("FAIL conflict stall cycles: got %0d expected 4", stalls);
      end
   endtask

   task automatic test_store_replay();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      cur_test = "store_replay";
      q = '{mk(1'b0, 1'b1, 10'h00C, 1'b0, 1'b1, 4'hF, 10'h00C, 32'hCAFE_F00D),
            mk(1'b0, 1'b1, 10'h00C, 1'b0, 1'b0, 4'h0, 10'h0,   32'h0),
            idle()};
      foreach (q[i]) begin
         drive(q[i]);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
         if (i == 1) begin
            checks++;
            if (bus.instruction !== 32'hCAFE_F00D) begin
               errors++; $display("FAIL store_replay word: got %h expected cafef00d", bus.instruction);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      cur_test = "back_to_back";
      q.push_back(mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'hF, 10'h030, 32'h0BAD_CAFE));
      q.push_back(mk(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 4'h0, 10'h030, 32'h0));
      for (int k = 0; k < 16; k++)
         q.push_back(mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b1, 4'hF, 10'(k * 4), $urandom()));
      for (int k = 0; k < 150; k++)
         q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 10'($urandom_range(0, 63)), $urandom()));
      q.push_back(idle());
      foreach (q[i]) begin
         drive(q[i]);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s cycle %0d: got %h expected %h", cur_test, e.name, cyc, got, e.val);
            end
         end
         if (i == 1) begin
            checks++;
            if (bus.data_in !== 32'h0BAD_CAFE) begin
               errors++; $display("FAIL store then load: got %h expected 0badcafe", bus.data_in);
            end
         end
      end
   endtask

   task automatic test_reset_replay();
      stim_t q[$];
      exp_t e;
      logic [31:0] got;
      cur_test = "reset_replay";
      q = '{mk(1'b0, 1'b0, 10'h0,   1'b0, 1'b1, 4'hF, 10'h014, 32'hDEAD_BEEF),
            mk(1'b0, 1'b1, 10'h014, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0),
            mk(1'b1, 1'b1, 10'h014, 1'b0, 1'b0, 4'h0, 10'h0,   32'h0),
            idle(), idle()};
      foreach (q[i]) begin
         drive(q[i]);
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0: got = bus.instruction;
               1: got = bus.data_in;
               2: got = {31'b0, last_stall};
               default: got = cnt_obs;
            endcase
            checks++;
            if (got !== e.val) begin
               errors++;
               $display("FAIL %s %s: got %h expected %h", cur_test, e.name, got, e.val);
            end
         end
         if (i >= 2) begin
            checks++;
            if (bus.instruction !== NOP) begin
               errors++; $display("FAIL reset_replay inst step %0d: got %h expected %h", i, bus.instruction, NOP);
            end
         end
         if (i == 3) begin
            checks++;
            if (last_stall !== 1'b0) begin
               errors++; $display("FAIL reset_replay stall: got %b expected 0", last_stall);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_byte_lanes();
      test_conflict();
      test_store_replay();
      test_back_to_back();
      test_reset_replay();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the RV32I_CPU instruction and data ports.
- Holds one single-port word array that serves both instruction fetches and data loads/stores.
- Arbitrates between them; data wins a conflict, and the responder asserts mem_stall while the fetch is replayed.
- Sits beside the CPU top level and replaces separate instruction and data memories.

Parameters:
ADDR_W, 10, byte-address width of both ports; array depth is 2^(ADDR_W-2) words
NOP_WORD, 32'h00000013, value driven on instruction during reset and fetch bubbles

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instruction_address  input  ADDR_W  byte address of the fetch; word index = [ADDR_W-1:2]
- read_inst_enable  input  1  fetch request this cycle
- instruction  output  32  fetched word, registered
- data_address  input  ADDR_W  byte address of the data access; word index = [ADDR_W-1:2]
- data_read  input  1  load request this cycle
- write_mem  input  1  store request this cycle
- width  input  4  byte-lane enables for stores; bit i writes bits [8i+7:8i]
- data_out  input  32  store data, already lane-aligned by the CPU
- data_in  output  32  load result (full word), registered
- mem_stall  output  1  CPU must hold PC and fetch inputs

Behaviour:
- Reset (synchronous, active-high), applied on the next edge:
  - instruction = NOP_WORD, data_in = 0, mem_stall = 0, state = IDLE, pending fetch address = 0.
  - Array contents are not reset.
  - Reset asserted mid-replay abandons the pending fetch.
- Read latency is one cycle for both ports. Lower two address bits are ignored; there is no misalignment fault.
- Data request: dreq = data_read | write_mem.
  - If write_mem and data_read are both high, the store is performed and data_in holds its previous value.
- Store with width == 0 is a no-op access. It still takes the port and causes a conflict.
- States:
  - IDLE:
    - No dreq, fetch requested: read the array at instruction_address; instruction <= word next cycle.
    - No dreq, read_inst_enable low: instruction <= NOP_WORD next cycle (bubble).
    - dreq only (read_inst_enable low): perform the data access; instruction <= NOP_WORD; no stall; stay in IDLE.
    - dreq and fetch together: perform the data access; latch instruction_address into the pending register; assert mem_stall combinationally this cycle; instruction holds its previous value; go to REPLAY.
  - REPLAY:
    - Perform the pending fetch. mem_stall stays high this cycle; instruction updates at the end of the cycle.
    - dreq in this cycle is ignored. The CPU is stalled and must not present a new data access.
    - Return to IDLE; mem_stall is low in the following cycle.
- Store followed by a fetch of the same word: the replay reads the newly written data, because the write completes before the replay read.
- Store followed by a load of the same word in the next cycle returns the new data.
- The array read is unregistered-address, registered-output (single port, inferable as block RAM).
- No output changes except as listed above.

Optional Feature:
STALL_COUNT_EN
- With macro: adds output stall_count [31:0].
  - Resets to 0; increments on each cycle mem_stall is high; saturates at 32'hFFFFFFFF.
- Without macro: port is absent and no counter logic is built.

Test Plan:
- Reset held 2 cycles, then released with no requests -> instruction = 32'h00000013, data_in = 0, mem_stall = 0.
- Preload word 5 = 32'hDEADBEEF; fetch instruction_address = 10'h014 -> instruction = 32'hDEADBEEF one cycle later, mem_stall never high.
- Store data_out = 32'h11223344, width = 4'b0101 at address 10'h020 over old word 32'hAABBCCDD; then load 10'h020 -> data_in = 32'hAA22CC44.
- Fetch at 10'h004 plus load at 10'h008 in the same cycle:
  - mem_stall = 1 for 2 cycles; data_in = word 2 after cycle 1; instruction = word 1 after cycle 2; stall_count = 2 with STALL_COUNT_EN.
- Store 32'hCAFEF00D (width 4'hF) to 10'h00C together with a fetch of 10'h00C -> the replayed instruction = 32'hCAFEF00D.
- Reset asserted during REPLAY -> next cycle mem_stall = 0, instruction = NOP_WORD, state IDLE; the pending fetch is never delivered.
